mult_row_sequencer: RTL and testbench
=====================================

Name: mult_row_sequencer

Overview:
- Controller for the row multiplier: runs the multiplier over output rows 0..NUM_ROWS-1 and captures each row result.
- Writes each row result to the result buffer and tracks a signed argmax for classification.
- Sits between the top-level control FSM (start/abort) and the multiplier's begin_mult/row_select/done_row/row_result/overflow interface.

Parameters:
NUM_ROWS, 10, number of output rows, one per class (digits 0-9)
ROW_W, 4, width of row index; must satisfy 2**ROW_W >= NUM_ROWS
RES_W, 32, width of multiplier row_result
TIMEOUT, 1023, maximum cycles to wait for done_row after begin (a row needs ~392+ cycles)

Ports:
clk  in  1  system clock, rising edge
n_rst  in  1  asynchronous active-low reset
start  in  1  one-cycle request to run all rows; ignored unless idle, done or error
abort  in  1  synchronous abort; returns to IDLE from any state
mult_begin  out  1  one-cycle begin pulse to the multiplier
mult_row_select  out  ROW_W  row currently being computed
mult_done_row  in  1  multiplier row-complete flag; may be held high as a level
mult_row_result  in  RES_W  signed row result from the multiplier, valid when done_row rises
mult_overflow  in  1  multiplier overflow flag, sampled with the result
res_w_ena  out  1  result buffer write strobe, one cycle per row
res_w_addr  out  ROW_W  result buffer address (= row)
res_w_data  out  RES_W  captured row result
busy  out  1  high from ISSUE through CAPTURE
done  out  1  one-cycle pulse when the last row has been captured
class_valid  out  1  high from done until the next start, abort or reset
class_out  out  ROW_W  index of the row with the maximum signed result
max_value  out  RES_W  that maximum value
any_overflow  out  1  sticky OR of captured overflow flags for the current run
timeout_err  out  1  sticky error flag; cleared by start, abort or reset

Behaviour:
- Reset values: all outputs 0; state IDLE; row 0; done_prev 0; timer 0.
- States: IDLE, ISSUE, WAIT, CAPTURE, DONE, ERR.
- All outputs are registered or Moore-decoded from state; there is no combinational path from inputs to outputs.
- IDLE/DONE/ERR with start=1:
  - Next state ISSUE; row cleared to 0.
  - max_value, any_overflow, class_valid and timeout_err cleared.
  - A first_row flag is set.
- ISSUE (1 cycle):
  - mult_begin=1; mult_row_select=row; timer cleared.
  - Next state WAIT.
  - First mult_begin appears exactly 1 cycle after start is sampled.
- WAIT:
  - done_prev<=mult_done_row every cycle in all states.
  - A rising edge (mult_done_row & ~done_prev) latches mult_row_result and mult_overflow, then goes to CAPTURE.
  - An edge present during ISSUE is ignored.
  - Otherwise timer increments; when timer reaches TIMEOUT with no edge, go to ERR.
- CAPTURE (1 cycle):
  - res_w_ena=1, res_w_addr=row, res_w_data=latched result.
  - any_overflow |= latched overflow.
  - Argmax update, signed compare: if first_row, or result > max_value (strict), then max_value<=result and class_out<=row. Ties keep the lower index. Overflowed rows still take part.
  - first_row cleared.
  - If row==NUM_ROWS-1, go to DONE; else row++ and go to ISSUE.
- DONE:
  - done=1 for the entry cycle only; class_valid=1 held.
  - Remains in DONE (waiting for start) with done low after the first cycle.
- ERR:
  - timeout_err=1 held; busy=0; class_valid=0; no further mult_begin.
  - Left only by start, abort or reset.
- abort=1 in any state:
  - Next state IDLE; busy, class_valid and res_w_ena drop the next cycle.
  - No done pulse; an in-flight capture is discarded.
  - abort has priority over start in the same cycle.
- start while busy: ignored.
- mult_row_select holds its value between rows and during WAIT; it is 0 in IDLE.
- Reset mid-run: immediate asynchronous return to reset values.
- Per-row cost: 1 (ISSUE) + multiplier latency + 1 (edge detect) + 1 (CAPTURE).

Decomposition:
- Package mult_seq_pkg:
  - state enum seq_state_t {IDLE, ISSUE, WAIT, CAPTURE, DONE, ERR}
  - constants NUM_ROWS, ROW_W, RES_W, TIMEOUT
  - typedefs row_idx_t, row_res_t
- Sub-module argmax_tracker: clear, update strobe, index and signed value inputs; outputs max_value and class_out; strict-greater replace with first-sample load.
- The FSM, timer and edge detect live in mult_row_sequencer.

Test Plan:
- Behavioural multiplier model, done_row 400 cycles after begin, results row r = 784*(r+1). start → 10 mult_begin pulses with row_select 0..9; 10 res_w_ena writes with addr=r and data=784*(r+1); done pulse; class_out=9; max_value=7840; any_overflow=0.
- Signed results {-5,-3,-3,-100,...,-200} (row1=row2=-3, others below) → class_out=1 (tie goes to the lower index); max_value=-3 (0xFFFFFFFD).
- Row 4 reports overflow=1 with result 0x7FFFFFFF, all others 784 → any_overflow=1 after run; class_out=4.
- Model never raises done_row on row 2 → timeout_err=1 exactly TIMEOUT+1 cycles after WAIT entry; only 2 writes occurred; no done; next start clears timeout_err and reruns from row 0.
- abort asserted during WAIT of row 5 → IDLE next cycle; busy=0; no done; class_valid=0; row_select=0; a late done_row edge produces no write.
- done_row held high for 50 cycles and start pulsed while busy → a single capture per row; start ignored; the run completes normally with exactly 10 writes.

Source files
------------

// File: rtl/mult_seq_pkg.sv
// Shared types and constants for the row multiplier sequencer.
package mult_seq_pkg;

  localparam int NUM_ROWS = 10;
  localparam int ROW_W    = 4;
  localparam int RES_W    = 32;
  localparam int TIMEOUT  = 1023;
  localparam int TMR_W    = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    CAPTURE,
    DONE,
    ERR
  } seq_state_t;

  typedef logic [ROW_W-1:0]        row_idx_t;
  typedef logic signed [RES_W-1:0] row_res_t;
  typedef logic [TMR_W-1:0]        tmr_t;

  localparam row_idx_t LAST_ROW = row_idx_t'(NUM_ROWS - 1);

endpackage

// File: rtl/mult_row_sequencer_argmax.sv
// Signed running maximum with the index of the row that produced it.
module argmax_tracker
  import mult_seq_pkg::*;
(
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    update,
  input  logic                    first,
  input  logic [ROW_W-1:0]        idx,
  input  logic signed [RES_W-1:0] value,
  output logic signed [RES_W-1:0] max_value,
  output logic [ROW_W-1:0]        class_out
);

  // First sample always loads; later samples replace only on strictly greater, so ties keep the lower row.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      max_value <= '0;
      class_out <= '0;
    end else if (clear) begin
      max_value <= '0;
    end else if (update && (first || (value > max_value))) begin
      max_value <= value;
      class_out <= idx;
    end
  end

endmodule

// File: rtl/mult_row_sequencer.sv
// Runs the row multiplier over every output row, writes each result and tracks the argmax.
//
// state   | meaning
// IDLE    | waiting for start
// ISSUE   | one-cycle begin pulse for the current row, timer loaded
// WAIT    | waiting for a done_row rising edge, timer counting down
// CAPTURE | write result, update argmax, advance row
// DONE    | all rows captured, classification valid
// ERR     | multiplier never answered; held until start/abort
module mult_row_sequencer
  import mult_seq_pkg::*;
(
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  input  logic             abort,
  output logic             mult_begin,
  output logic [ROW_W-1:0] mult_row_select,
  input  logic             mult_done_row,
  input  logic [RES_W-1:0] mult_row_result,
  input  logic             mult_overflow,
  output logic             res_w_ena,
  output logic [ROW_W-1:0] res_w_addr,
  output logic [RES_W-1:0] res_w_data,
  output logic             busy,
  output logic             done,
  output logic             class_valid,
  output logic [ROW_W-1:0] class_out,
  output logic [RES_W-1:0] max_value,
  output logic             any_overflow
  ,output logic            timeout_err
);

  seq_state_t state, state_nxt;
  row_idx_t   row;
  tmr_t       timer;
  row_res_t   lat_res;
  logic       lat_ovf;
  logic       done_prev;
  logic       first_row;
  logic       any_ovf_q;
  logic       done_q;
  logic       row_edge;
  logic       start_ok;
  logic       capture_ok;

  assign row_edge   = mult_done_row & ~done_prev;
  assign start_ok   = start & ~abort & ((state == IDLE) || (state == DONE) || (state == ERR));
  assign capture_ok = (state == CAPTURE) & ~abort;

  // Next-state decode; abort outranks every other transition.
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE, DONE, ERR: if (start) state_nxt = ISSUE;
        ISSUE:           state_nxt = WAIT;
        WAIT: begin
          if (row_edge)            state_nxt = CAPTURE;
          else if (timer == '0)    state_nxt = ERR;
        end
        CAPTURE:         state_nxt = (row == LAST_ROW) ? DONE : ISSUE;
        default:         state_nxt = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  // Row counter, timeout down-counter, result latch and per-run flags.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      row       <= '0;
      timer     <= '0;
      lat_res   <= '0;
      lat_ovf   <= 1'b0;
      done_prev <= 1'b0;
      first_row <= 1'b0;
      any_ovf_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_prev <= mult_done_row;
      done_q    <= 1'b0;
      if (abort) begin
        row <= '0;
      end else begin
        case (state)
          IDLE, DONE, ERR: begin
            if (start) begin
              row       <= '0;
              any_ovf_q <= 1'b0;
              first_row <= 1'b1;
            end
          end
          ISSUE: timer <= tmr_t'(TIMEOUT);
          WAIT: begin
            if (row_edge) begin
              lat_res <= mult_row_result;
              lat_ovf <= mult_overflow;
            end else if (timer != '0) begin
              timer <= timer - 1'b1;
            end
          end
          CAPTURE: begin
            any_ovf_q <= any_ovf_q | lat_ovf;
            first_row <= 1'b0;
            if (row == LAST_ROW) done_q <= 1'b1;
            else                 row    <= row + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  argmax_tracker u_argmax (
    .clk       (clk),
    .n_rst     (n_rst),
    .clear     (start_ok),
    .update    (capture_ok),
    .first     (first_row),
    .idx       (row),
    .value     (lat_res),
    .max_value (max_value),
    .class_out (class_out)
  );

  assign mult_begin      = (state == ISSUE);
  assign mult_row_select = row;
  assign res_w_ena       = (state == CAPTURE);
  assign res_w_addr      = row;
  assign res_w_data      = lat_res;
  assign busy            = (state == ISSUE) || (state == WAIT) || (state == CAPTURE);
  assign done            = done_q;
  assign class_valid     = (state == DONE);
  assign any_overflow    = any_ovf_q;
  assign timeout_err     = (state == ERR);

endmodule

// File: tb/tb_mult_row_sequencer.sv
// Scoreboard bench: stimulus queues expected begins/writes, a negedge monitor pops and compares.
module tb_mult_row_sequencer;

  localparam int NROWS = 10;
  localparam int LAT   = 400;
  localparam int TMO   = 1023;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        mult_begin;
  logic [3:0]  mult_row_select;
  logic        mult_done_row = 1'b0;
  logic [31:0] mult_row_result = '0;
  logic        mult_overflow = 1'b0;
  logic        res_w_ena;
  logic [3:0]  res_w_addr;
  logic [31:0] res_w_data;
  logic        busy;
  logic        done;
  logic        class_valid;
  logic [3:0]  class_out;
  logic [31:0] max_value;
  logic        any_overflow;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  logic [31:0] res_tab [NROWS];
  logic        ovf_tab [NROWS];
  int          never_row = -1;
  int          hold_len  = 3;

  int          exp_begin [$];
  logic [3:0]  exp_addr  [$];
  logic [31:0] exp_data  [$];

  always #5 clk = ~clk;

  mult_row_sequencer dut (
    .clk             (clk),
    .n_rst           (n_rst),
    .start           (start),
    .abort           (abort),
    .mult_begin      (mult_begin),
    .mult_row_select (mult_row_select),
    .mult_done_row   (mult_done_row),
    .mult_row_result (mult_row_result),
    .mult_overflow   (mult_overflow),
    .res_w_ena       (res_w_ena),
    .res_w_addr      (res_w_addr),
    .res_w_data      (res_w_data),
    .busy            (busy),
    .done            (done),
    .class_valid     (class_valid),
    .class_out       (class_out),
    .max_value       (max_value),
    .any_overflow    (any_overflow),
    .timeout_err     (timeout_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Multiplier model: result appears LAT cycles after begin and stays high hold_len cycles.
  int model_cnt  = 0;
  int model_hold = 0;
  int model_row  = 0;
  always @(negedge clk) begin
    if (model_hold > 0) begin
      model_hold--;
      if (model_hold == 0) mult_done_row = 1'b0;
    end
    if (n_rst && mult_begin) begin
      model_row = int'(mult_row_select);
      model_cnt = LAT;
    end else if (model_cnt > 0) begin
      model_cnt--;
      if (model_cnt == 0 && model_row != never_row && model_row < NROWS) begin
        mult_row_result = res_tab[model_row];
        mult_overflow   = ovf_tab[model_row];
        mult_done_row   = 1'b1;
        model_hold      = hold_len;
      end
    end
  end

  // Monitor: compare every begin and every buffer write against the queued expectations.
  always @(negedge clk) begin
    if (n_rst) begin
      if (mult_begin) begin
        if (exp_begin.size() == 0) begin
          checks++; errors++;
          $display("FAIL begin_unexpected: got row %0d expected no begin at %0t", mult_row_select, $time);
        end else begin
          int r;
          r = exp_begin.pop_front();
          chk("begin_row", 32'(mult_row_select), 32'(r));
        end
      end
      if (res_w_ena) begin
        if (exp_addr.size() == 0) begin
          checks++; errors++;
          $display("FAIL write_unexpected: got addr %0d data 0x%08h expected no write at %0t",
                   res_w_addr, res_w_data, $time);
        end else begin
          logic [3:0]  a;
          logic [31:0] d;
          a = exp_addr.pop_front();
          d = exp_data.pop_front();
          chk("write_addr", 32'(res_w_addr), 32'(a));
          chk("write_data", res_w_data, d);
        end
      end
      if (done) done_cnt++;
    end
  end

  task automatic set_default();
    for (int r = 0; r < NROWS; r++) begin
      res_tab[r] = 32'(784 * (r + 1));
      ovf_tab[r] = 1'b0;
    end
    never_row = -1;
    hold_len  = 3;
  endtask

  task automatic push_expect(input int last_begin);
    for (int r = 0; r <= last_begin; r++) begin
      exp_begin.push_back(r);
      if (r == never_row) break;
      if (r < last_begin || last_begin == NROWS - 1) begin
        exp_addr.push_back(4'(r));
        exp_data.push_back(res_tab[r]);
      end
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done_check(input string nm, input logic [3:0] ecls,
                                 input logic [31:0] emax, input logic eovf);
    int n;
    int d0;
    n  = 0;
    d0 = done_cnt;
    while (!done && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s_done_timeout: got no done after %0d cycles expected done", nm, n);
    end else begin
      chk({nm, "_class_valid"}, 32'(class_valid), 32'd1);
      chk({nm, "_class_out"}, 32'(class_out), 32'(ecls));
      chk({nm, "_max_value"}, max_value, emax);
      chk({nm, "_any_overflow"}, 32'(any_overflow), 32'(eovf));
      @(negedge clk);
      chk({nm, "_done_pulse_width"}, 32'(done), 32'd0);
      chk({nm, "_class_valid_held"}, 32'(class_valid), 32'd1);
      chk({nm, "_done_count"}, 32'(done_cnt - d0), 32'd1);
    end
    chk({nm, "_writes_left"}, 32'(exp_addr.size()), 32'd0);
    chk({nm, "_begins_left"}, 32'(exp_begin.size()), 32'd0);
  endtask

  task automatic wait_begin_row(input int r, input string nm);
    int n;
    n = 0;
    while (!(mult_begin && mult_row_select == 4'(r)) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!(mult_begin && mult_row_select == 4'(r))) begin
      checks++; errors++;
      $display("FAIL %s_wait_begin: got no begin for row %0d expected one", nm, r);
    end
  endtask

  initial begin
    set_default();
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_begin", 32'(mult_begin), 0);
    chk("rst_row_select", 32'(mult_row_select), 0);
    chk("rst_class_valid", 32'(class_valid), 0);
    chk("rst_timeout_err", 32'(timeout_err), 0);
    chk("rst_max_value", max_value, 0);
    chk("rst_class_out", 32'(class_out), 0);
    chk("rst_res_w_ena", 32'(res_w_ena), 0);
    @(negedge clk) n_rst = 1'b1;
    repeat (2) @(negedge clk);

    // Basic run: 784*(r+1); first begin one cycle after start.
    push_expect(NROWS - 1);
    pulse_start();
    chk("basic_first_begin_latency", 32'(mult_begin), 1);
    chk("basic_busy", 32'(busy), 1);
    wait_done_check("basic", 4'd9, 32'd7840, 1'b0);
    repeat (5) @(negedge clk);
    chk("basic_done_state_held", 32'(class_valid), 1);

    // Signed tie between rows 1 and 2.
    res_tab[0] = -32'sd5;   res_tab[1] = -32'sd3;   res_tab[2] = -32'sd3;
    res_tab[3] = -32'sd100; res_tab[4] = -32'sd110; res_tab[5] = -32'sd120;
    res_tab[6] = -32'sd130; res_tab[7] = -32'sd140; res_tab[8] = -32'sd150;
    res_tab[9] = -32'sd200;
    push_expect(NROWS - 1);
    pulse_start();
    chk("tie_class_valid_cleared", 32'(class_valid), 0);
    wait_done_check("tie", 4'd1, 32'hFFFF_FFFD, 1'b0);

    // Overflowed row still wins argmax.
    for (int r = 0; r < NROWS; r++) res_tab[r] = 32'd784;
    res_tab[4] = 32'h7FFF_FFFF;
    ovf_tab[4] = 1'b1;
    push_expect(NROWS - 1);
    pulse_start();
    wait_done_check("ovf", 4'd4, 32'h7FFF_FFFF, 1'b1);

    // done_row held as a long level, plus a start while busy.
    set_default();
    hold_len = 50;
    push_expect(NROWS - 1);
    pulse_start();
    chk("hold_any_overflow_cleared", 32'(any_overflow), 0);
    repeat (100) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_done_check("hold", 4'd9, 32'd7840, 1'b0);
    repeat (60) @(negedge clk);

    // Row 2 never completes: timeout after TIMEOUT+1 WAIT cycles.
    set_default();
    never_row = 2;
    begin
      int d0;
      d0 = done_cnt;
      push_expect(2);
      pulse_start();
      wait_begin_row(2, "tmo");
      repeat (TMO + 1) @(negedge clk);
      chk("tmo_not_yet", 32'(timeout_err), 0);
      @(negedge clk);
      chk("tmo_err_set", 32'(timeout_err), 1);
      chk("tmo_busy", 32'(busy), 0);
      chk("tmo_class_valid", 32'(class_valid), 0);
      repeat (30) @(negedge clk);
      chk("tmo_err_held", 32'(timeout_err), 1);
      chk("tmo_writes_left", 32'(exp_addr.size()), 0);
      chk("tmo_begins_left", 32'(exp_begin.size()), 0);
      chk("tmo_no_done", 32'(done_cnt - d0), 0);
    end
    never_row = -1;
    push_expect(NROWS - 1);
    pulse_start();
    chk("tmo_rerun_err_cleared", 32'(timeout_err), 0);
    chk("tmo_rerun_row0", 32'(mult_row_select), 0);
    wait_done_check("rerun", 4'd9, 32'd7840, 1'b0);

    // Abort during WAIT of row 5; the late done_row edge must not write.
    set_default();
    begin
      int d0;
      d0 = done_cnt;
      push_expect(5);
      pulse_start();
      wait_begin_row(5, "abort");
      repeat (10) @(negedge clk);
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      chk("abort_busy", 32'(busy), 0);
      chk("abort_class_valid", 32'(class_valid), 0);
      chk("abort_row_select", 32'(mult_row_select), 0);
      chk("abort_begin", 32'(mult_begin), 0);
      repeat (500) @(negedge clk);
      chk("abort_writes_left", 32'(exp_addr.size()), 0);
      chk("abort_begins_left", 32'(exp_begin.size()), 0);
      chk("abort_no_done", 32'(done_cnt - d0), 0);
      chk("abort_idle_busy", 32'(busy), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
